// File: rtl/dm_bus_arbiter_if.sv
// Bundle between NumReq upstream requesters, the arbiter, and the shared debug-module bus host port.
// The master modport is the arbiter's view; slave is the environment's view.
interface dm_bus_arbiter_if #(
  parameter int NumReq   = 2,
  parameter int BusWidth = 32
);
  localparam int BeW = BusWidth / 8;

  logic [NumReq-1:0]          m_req;
  logic [NumReq-1:0]          m_we;
  logic [NumReq*BeW-1:0]      m_be;
  logic [NumReq*BusWidth-1:0] m_addr;
  logic [NumReq*BusWidth-1:0] m_wdata;
  logic [NumReq-1:0]          m_gnt;
  logic [NumReq-1:0]          m_r_valid;
  logic [BusWidth-1:0]        m_rdata;
  logic                       m_r_err;
  logic                       m_r_other_err;

  logic                       bus_req;
  logic                       bus_we;
  logic [BeW-1:0]             bus_be;
  logic [BusWidth-1:0]        bus_addr;
  logic [BusWidth-1:0]        bus_wdata;
  logic                       bus_gnt;
  logic                       bus_r_valid;
  logic [BusWidth-1:0]        bus_rdata;
  logic                       bus_r_err;
  logic                       bus_r_other_err;

  modport master (
    input  m_req, m_we, m_be, m_addr, m_wdata,
    output m_gnt, m_r_valid, m_rdata, m_r_err, m_r_other_err,
    output bus_req, bus_we, bus_be, bus_addr, bus_wdata,
    input  bus_gnt, bus_r_valid, bus_rdata, bus_r_err, bus_r_other_err
  );

  modport slave (
    output m_req, m_we, m_be, m_addr, m_wdata,
    input  m_gnt, m_r_valid, m_rdata, m_r_err, m_r_other_err,
    input  bus_req, bus_we, bus_be, bus_addr, bus_wdata,
    output bus_gnt, bus_r_valid, bus_rdata, bus_r_err, bus_r_other_err
  );
endinterface

// File: rtl/dm_bus_arbiter.sv
// Round-robin arbiter sharing one debug-module bus host port; one outstanding
// transaction, with a per-phase watchdog that completes hung transfers as r_other_err.
module dm_bus_arbiter #(
  parameter int NumReq        = 2,
  parameter int BusWidth      = 32,
  parameter int TimeoutCycles = 255
) (
  input logic              clk,
  input logic              rst,
  dm_bus_arbiter_if.master bus_if
);
  localparam int BeW  = BusWidth / 8;
  localparam int SelW = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int TW   = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam logic [TW-1:0] TLim = TW'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);

  typedef enum logic [1:0] {IDLE, ADDR, RESP} state_e;

  state_e              state, state_n;
  logic [SelW-1:0]     sel, last, pick, pick_hi;
  logic                hi_found;
  logic                we_q;
  logic [BeW-1:0]      be_q;
  logic [BusWidth-1:0] addr_q, wdata_q;
  logic [TW-1:0]       timer;
  logic                timeout;
  logic                gnt_fire, rv_fire, rv_real, done;

  // Lowest requester above 'last' wins; otherwise wrap to the lowest requester overall.
  always_comb begin
    pick     = last;
    pick_hi  = last;
    hi_found = 1'b0;
    for (int i = NumReq - 1; i >= 0; i--) begin
      if (bus_if.m_req[i]) pick = SelW'(i);
      if (bus_if.m_req[i] && (i > int'(last))) begin
        pick_hi  = SelW'(i);
        hi_found = 1'b1;
      end
    end
    if (hi_found) pick = pick_hi;
  end

  assign timeout = (TimeoutCycles != 0) && (timer == TLim);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n  = state;
    gnt_fire = 1'b0;
    rv_fire  = 1'b0;
    rv_real  = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: if (|bus_if.m_req) state_n = ADDR;
      ADDR: begin
        if (bus_if.bus_gnt) begin
          gnt_fire = 1'b1;
          state_n  = RESP;
        end else if (timeout) begin
          gnt_fire = 1'b1;
          rv_fire  = 1'b1;
          done     = 1'b1;
          state_n  = IDLE;
        end
      end
      RESP: begin
        // A stray r_valid outside RESP never reaches this branch, so it is dropped.
        if (bus_if.bus_r_valid) begin
          rv_fire = 1'b1;
          rv_real = 1'b1;
          done    = 1'b1;
          state_n = IDLE;
        end else if (timeout) begin
          rv_fire = 1'b1;
          done    = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    if (rst) begin
      gnt_fire = 1'b0;
      rv_fire  = 1'b0;
      rv_real  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel     <= '0;
      last    <= SelW'(NumReq - 1);
      timer   <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      if (state == IDLE && state_n == ADDR) begin
        sel     <= pick;
        we_q    <= bus_if.m_we[pick];
        be_q    <= bus_if.m_be[pick*BeW +: BeW];
        addr_q  <= bus_if.m_addr[pick*BusWidth +: BusWidth];
        wdata_q <= bus_if.m_wdata[pick*BusWidth +: BusWidth];
      end
      if (done) last <= sel;
      // Timer restarts on every phase entry and runs only while a phase is open.
      if (state_n != state)   timer <= '0;
      else if (state != IDLE) timer <= timer + 1'b1;
    end
  end

  assign bus_if.bus_req   = (state == ADDR);
  assign bus_if.bus_we    = we_q;
  assign bus_if.bus_be    = be_q;
  assign bus_if.bus_addr  = addr_q;
  assign bus_if.bus_wdata = wdata_q;

  assign bus_if.m_rdata       = rv_real ? bus_if.bus_rdata : '0;
  assign bus_if.m_r_other_err = rv_fire & (~rv_real | bus_if.bus_r_other_err);
  assign bus_if.m_r_err       = rv_real & bus_if.bus_r_err & ~bus_if.bus_r_other_err;

  for (genvar i = 0; i < NumReq; i++) begin : g_route
    assign bus_if.m_gnt[i]     = gnt_fire & (sel == SelW'(i));
    assign bus_if.m_r_valid[i] = rv_fire  & (sel == SelW'(i));
  end
endmodule
